toast_inst_stream_encoder: RTL and testbench
============================================

Name: toast_inst_stream_encoder

Overview:
- Sits directly upstream of the core's instruction-fetch path in the Toast-RV32i verification environment.
- Accepts abstract instruction transactions (kind from the shared instruction_t enum plus operand fields) over a valid/ready handshake.
- Encodes each transaction to a 32-bit RV32I word, buffers it in a FIFO, and presents the words as a valid/ready stream to the fetch side.
- Flags unsupported kinds and counts them.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the error counter; saturates at all-ones.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_valid  in  1  transaction present.
- o_ready  out  1  transaction accepted when i_valid and o_ready are both high.
- i_kind  in  32  instruction_t value.
- i_rd  in  5  destination register; ignored for NOP.
- i_imm  in  20  upper immediate for LUI; ignored for NOP.
- i_flush  in  1  synchronous clear of all FIFO contents.
- o_valid  out  1  encoded word available.
- i_ready  in  1  consumer takes the word when o_valid and i_ready are both high.
- o_inst  out  32  encoded instruction word.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_err  out  1  one-cycle pulse on acceptance of an unsupported kind.
- o_err_cnt  out  CNT_W  total number of unsupported kinds accepted.

Behaviour:
- Reset: o_valid=0, o_inst=0, o_count=0, o_err=0, o_err_cnt=0, o_ready=1. Pointers return to 0. Contents are discarded mid-operation, including any in-flight handshake.
- Encoding (combinational, at acceptance):
  - inst_NOP → 32'h00000013 (ADDI x0,x0,0).
  - inst_LUI → {i_imm, i_rd, 7'b0110111}.
  - Any other kind → not written to the FIFO; o_err pulses the following cycle; o_err_cnt increments, saturating.
- o_ready = !full. It is a function of registered state only and never depends on i_ready.
- Push: accept with a supported kind writes mem[wptr] and advances wptr, wrapping modulo DEPTH.
- Pop: o_valid && i_ready advances rptr, wrapping modulo DEPTH.
- Write latency: a word accepted in cycle N is visible on o_inst with o_valid=1 in cycle N+1.
- Output data: o_inst = mem[rptr] while o_valid=1. o_inst is held stable until popped; it is undefined-but-stable (last value) when o_valid=0.
- Simultaneous push and pop: when not empty and not full, o_count is unchanged. When empty, the pop is impossible and only the push applies. When full, o_ready=0, so only the pop applies.
- o_valid = (o_count != 0).
- Flush: i_flush takes priority over push and pop in the same cycle. Next cycle: o_count=0, o_valid=0, pointers at 0.
  - A transaction handshaked in the flush cycle is dropped, including its error pulse.
  - o_err_cnt is not cleared by flush.
- Full boundary: o_count == DEPTH implies o_ready=0. Empty boundary: o_count == 0 implies o_valid=0.

Optional Feature:
- Macro: TOAST_ENC_BYPASS_EN.
- Defined: when the FIFO is empty, i_flush=0, i_ready=1, and a supported transaction is accepted, the encoded word is driven on o_inst with o_valid=1 in the same cycle and is not stored. o_count stays 0.
  - In this mode o_valid and o_inst are combinational from the inputs.
  - Bypass requires o_ready=1, which always holds when the FIFO is empty.
- Undefined: always-registered path with one-cycle minimum latency, as described under Behaviour.

Decomposition:
- Shared package toast_OOP_package: instruction_t, plus constants OPC_LUI=7'b0110111, OPC_OP_IMM=7'b0010011, NOP_WORD=32'h00000013.
- Sub-module toast_inst_encode: purely combinational; inputs kind/rd/imm; outputs 32-bit word and a supported flag.
- FIFO and counters stay in the top module.

Test Plan:
- Reset, then push NOP → next cycle o_valid=1, o_inst=32'h00000013, o_count=1.
- Push LUI rd=5, imm=20'h12345 → o_inst=32'h123452B7. Push LUI rd=31, imm=20'hFFFFF → 32'hFFFFFFB7.
- Hold i_ready=0 and push 8 NOPs (DEPTH=8) → o_ready=0 and o_count=8. A 9th i_valid is not accepted. Release i_ready for 8 cycles → words drain in order, o_valid falls, and pointers wrap correctly on refill.
- Push kind=7 → nothing enters the FIFO, o_err high for exactly one cycle, o_err_cnt=1. Repeat with kind=2 → o_err_cnt=2.
- With 3 entries queued, assert i_flush while also pushing and popping → next cycle o_count=0, o_valid=0, and the pushed word never appears.
- With TOAST_ENC_BYPASS_EN, empty FIFO, i_ready=1, push LUI x1,0x00001 → same cycle o_valid=1, o_inst=32'h000010B7, o_count stays 0. Without the macro, the same word appears one cycle later.

Source files
------------

// File: rtl/toast_inst_stream_encoder_pkg.sv
// Shared instruction kinds and RV32I encoding constants for the Toast-RV32i
// instruction stream encoder.
package toast_OOP_package;

  typedef enum logic [31:0] {
    inst_NOP  = 32'd0,
    inst_LUI  = 32'd1,
    inst_ADDI = 32'd2,
    inst_ADD  = 32'd3,
    inst_JAL  = 32'd4,
    inst_BEQ  = 32'd5,
    inst_LW   = 32'd6,
    inst_SW   = 32'd7
  } instruction_t;

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_WORD   = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

endpackage

// File: rtl/toast_inst_stream_encoder_encode.sv
// Combinational encoder: abstract instruction kind plus operands to an RV32I word.
// Kinds other than NOP and LUI are reported as unsupported with a zero word.
module toast_inst_encode
  import toast_OOP_package::*;
(
  input  logic [31:0] kind,
  input  logic [4:0]  rd,
  input  logic [19:0] imm,
  output logic [31:0] word,
  output logic        supported
);

  always_comb begin
    word      = 32'd0;
    supported = 1'b0;
    case (kind)
      inst_NOP: begin
        word      = NOP_WORD;
        supported = 1'b1;
      end
      inst_LUI: begin
        word      = {imm, rd, OPC_LUI};
        supported = 1'b1;
      end
      default: begin
        word      = 32'd0;
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/toast_inst_stream_encoder.sv
// Instruction stream encoder: encodes accepted transactions into a FIFO feeding fetch.
// Optional macro TOAST_ENC_BYPASS_EN enables a zero-latency path when the FIFO is empty.
module toast_inst_stream_encoder
  import toast_OOP_package::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_kind,
  input  logic [4:0]               i_rd,
  input  logic [19:0]              i_imm,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_inst,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_err,
  output logic [CNT_W-1:0]         o_err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        full, empty, accept, push, pop, bypass;

  toast_inst_encode u_encode (
    .kind      (i_kind),
    .rd        (i_rd),
    .imm       (i_imm),
    .word      (enc_word),
    .supported (enc_ok)
  );

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign o_ready = !full;
  assign accept  = i_valid && o_ready;

`ifdef TOAST_ENC_BYPASS_EN
  assign bypass  = empty && !i_flush && i_ready && accept && enc_ok;
  assign o_valid = !empty || bypass;
  assign o_inst  = bypass ? enc_word : mem_q[rptr_q];
`else
  assign bypass  = 1'b0;
  assign o_valid = !empty;
  assign o_inst  = mem_q[rptr_q];
`endif

  // Flush wins over everything; a bypassed word is consumed directly and never stored.
  assign push = accept && enc_ok && !i_flush && !bypass;
  assign pop  = !empty && i_ready && !i_flush;

  assign o_count   = count_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    err_d     = accept && !enc_ok && !i_flush;
    err_cnt_d = err_cnt_q;

    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = enc_word;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_toast_inst_stream_encoder.sv
// Self-checking bench for toast_inst_stream_encoder: queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_toast_inst_stream_encoder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        outReady;
  logic [31:0] inKind;
  logic [4:0]  inRd;
  logic [19:0] inImm;
  logic        inFlush;
  logic        outValid;
  logic        inReady;
  logic [31:0] outInst;
  logic [3:0]  outCount;
  logic        outErr;
  logic [CNT_W-1:0] outErrCnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelQ[$];
  logic        modelErr = 1'b0;
  int          modelErrCnt = 0;

  toast_inst_stream_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (inValid),
    .o_ready   (outReady),
    .i_kind    (inKind),
    .i_rd      (inRd),
    .i_imm     (inImm),
    .i_flush   (inFlush),
    .o_valid   (outValid),
    .i_ready   (inReady),
    .o_inst    (outInst),
    .o_count   (outCount),
    .o_err     (outErr),
    .o_err_cnt (outErrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] k, input logic [4:0] r,
                               input logic [19:0] im, input logic fl, input logic rdy);
    @(negedge clk);
    inValid = v;
    inKind  = k;
    inRd    = r;
    inImm   = im;
    inFlush = fl;
    inReady = rdy;
  endtask

  function automatic logic modelSupported(input logic [31:0] k);
    return (k == 32'd0) || (k == 32'd1);
  endfunction

  function automatic logic [31:0] modelEncode(input logic [31:0] k, input logic [4:0] r, input logic [19:0] im);
    if (k == 32'd0) return 32'h00000013;
    return im * 32'd4096 + r * 32'd128 + 32'd55;
  endfunction

  function automatic logic modelBypass();
`ifdef TOAST_ENC_BYPASS_EN
    return (modelQ.size() == 0) && inValid && !inFlush && inReady && modelSupported(inKind);
`else
    return 1'b0;
`endif
  endfunction

  // Compare just before each rising edge, then advance the model with the same inputs.
  always begin
    logic byp;
    logic acc;
    @(negedge clk);
    #4;
    byp = modelBypass();
    if (!rst) begin
      checkOutput("ready", {31'd0, outReady}, {31'd0, modelQ.size() != DEPTH});
      checkOutput("valid", {31'd0, outValid}, {31'd0, (modelQ.size() != 0) || byp});
      checkOutput("count", {28'd0, outCount}, modelQ.size());
      checkOutput("err",   {31'd0, outErr}, {31'd0, modelErr});
      checkOutput("errcnt", {16'd0, outErrCnt}, modelErrCnt);
      if (byp)
        checkOutput("inst_bypass", outInst, modelEncode(inKind, inRd, inImm));
      else if (modelQ.size() != 0)
        checkOutput("inst", outInst, modelQ[0]);
    end
    if (rst) begin
      modelQ.delete();
      modelErr    = 1'b0;
      modelErrCnt = 0;
    end else begin
      acc      = inValid && (modelQ.size() < DEPTH);
      modelErr = acc && !modelSupported(inKind) && !inFlush;
      if (modelErr && modelErrCnt < (1 << CNT_W) - 1) modelErrCnt++;
      if (inFlush) begin
        modelQ.delete();
      end else begin
        if (modelQ.size() != 0 && inReady) void'(modelQ.pop_front());
        if (acc && modelSupported(inKind) && !byp) modelQ.push_back(modelEncode(inKind, inRd, inImm));
      end
    end
  end

  initial begin
    rst = 1'b1;
    inValid = 1'b0; inKind = 32'd0; inRd = 5'd0; inImm = 20'd0; inFlush = 1'b0; inReady = 1'b0;
    #3;
    checkOutput("rst_ready", {31'd0, outReady}, 32'd1);
    checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_inst", outInst, 32'd0);
    checkOutput("rst_count", {28'd0, outCount}, 32'd0);
    checkOutput("rst_err", {31'd0, outErr}, 32'd0);
    checkOutput("rst_errcnt", {16'd0, outErrCnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] NOP and LUI encoding");
    applyStimulus(1, 32'd0, 5'd3, 20'h0ABCD, 0, 0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("nop_valid", {31'd0, outValid}, 32'd1);
    checkOutput("nop_word", outInst, 32'h00000013);
    checkOutput("nop_count", {28'd0, outCount}, 32'd1);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    applyStimulus(1, 32'd1, 5'd5, 20'h12345, 0, 0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("lui_x5", outInst, 32'h123452B7);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    applyStimulus(1, 32'd1, 5'd31, 20'hFFFFF, 0, 0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("lui_x31", outInst, 32'hFFFFFFB7);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);

    $display("[TB] fill to full, drain, wrap");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 32'd1, 5'(i), 20'(i + 'h100), 0, 0);
    applyStimulus(1, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("full_ready", {31'd0, outReady}, 32'd0);
    checkOutput("full_count", {28'd0, outCount}, 32'd8);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("ninth_rejected", {28'd0, outCount}, 32'd8);
    checkOutput("full_head", outInst, 32'h00100037);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("drained_valid", {31'd0, outValid}, 32'd0);
    checkOutput("drained_count", {28'd0, outCount}, 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'd1, 5'(i + 10), 20'(i + 'h200), 0, 0);
    for (int i = 0; i < 7; i++)
      applyStimulus(1, 32'd1, 5'(i + 20), 20'(i + 'h300), 0, 1);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("pushpop_count", {28'd0, outCount}, 32'd3);

    $display("[TB] flush with push and pop");
    applyStimulus(1, 32'd1, 5'd9, 20'hABCDE, 1, 1);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    #4;
    checkOutput("flush_count", {28'd0, outCount}, 32'd0);
    checkOutput("flush_valid", {31'd0, outValid}, 32'd0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);

    $display("[TB] unsupported kinds");
    applyStimulus(1, 32'd7, 5'd1, 20'd1, 0, 0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("err_pulse", {31'd0, outErr}, 32'd1);
    checkOutput("err_cnt1", {16'd0, outErrCnt}, 32'd1);
    checkOutput("err_no_push", {28'd0, outCount}, 32'd0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("err_one_cycle", {31'd0, outErr}, 32'd0);
    applyStimulus(1, 32'd2, 5'd1, 20'd1, 0, 0);
    applyStimulus(1, 32'd3, 5'd1, 20'd1, 1, 0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 0);
    #4;
    checkOutput("err_flush_dropped", {31'd0, outErr}, 32'd0);
    checkOutput("err_cnt2", {16'd0, outErrCnt}, 32'd2);

    $display("[TB] bypass path");
    applyStimulus(1, 32'd1, 5'd1, 20'h00001, 0, 1);
    #4;
`ifdef TOAST_ENC_BYPASS_EN
    checkOutput("byp_same_valid", {31'd0, outValid}, 32'd1);
    checkOutput("byp_same_inst", outInst, 32'h000010B7);
    checkOutput("byp_count", {28'd0, outCount}, 32'd0);
`else
    checkOutput("reg_same_valid", {31'd0, outValid}, 32'd0);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    #4;
    checkOutput("reg_next_valid", {31'd0, outValid}, 32'd1);
    checkOutput("reg_next_inst", outInst, 32'h000010B7);
`endif
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    applyStimulus(0, 32'd0, 5'd0, 20'd0, 0, 1);
    #4;
    checkOutput("final_empty", {28'd0, outCount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
